// File: rtl/movegen_pkg.sv
// Shared move-generator types: a stack entry is a piece code over a board square.
package movegen_pkg;

   typedef logic [3:0] piece_t;
   typedef logic [5:0] square_t;

   typedef struct packed {
      piece_t  piece;
      square_t square;
   } entry_t;

   localparam piece_t PIECE_NONE = 4'd0;
   localparam int     ENTRY_W    = $bits(entry_t);

   // Pack a piece/square pair into a flat entry word.
   function automatic logic [ENTRY_W-1:0] make_entry(input piece_t p, input square_t s);
      entry_t e;
      e.piece  = p;
      e.square = s;
      return e;
   endfunction

endpackage

// File: rtl/movegen_lifo_cell.sv
// One storage cell of the shifting LIFO. The neighbours feed d_up (from the
// cell below, on pop) and d_dn (from the cell above, or in_data for cell 0,
// on push). While clear is high the cell empties unless ld_dn is set, which
// the top only does for cell 0 on clear+push.
module movegen_lifo_cell #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             ld_up,
   input  logic             ld_dn,
   input  logic [WIDTH-1:0] d_up,
   input  logic [WIDTH-1:0] d_dn,
   output logic [WIDTH-1:0] q
);

   // Cell register: reset, then clear (optionally reloading), then shift loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q <= ld_dn ? d_dn : '0;
      end else if (ld_dn) begin
         q <= d_dn;
      end else if (ld_up) begin
         q <= d_up;
      end
   end

endmodule

// File: rtl/movegen_piece_lifo.sv
// Piece/square LIFO between the square scanner and the move emitter.
// Cell 0 is the top of stack; push shifts entries toward DEPTH-1, pop shifts
// toward 0 and backfills zero, so every cell at index >= count stays 0.
// top_valid is a plain level: high whenever the stack holds an entry, and
// top_data is the entry a pop in the same cycle will discard.
module movegen_piece_lifo
   import movegen_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] top_data,
   output logic             top_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   logic [WIDTH-1:0] cell_q [DEPTH];
   logic [WIDTH-1:0] d_up   [DEPTH];
   logic [WIDTH-1:0] d_dn   [DEPTH];
   logic [DEPTH-1:0] ld_up;
   logic [DEPTH-1:0] ld_dn;

   logic push_shift;  // push that grows the stack (push+pop on empty included)
   logic replace;     // push+pop on a non-empty stack: overwrite top only
   logic pop_shift;   // pop that shrinks the stack

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Operation decode; clear masks every shifting operation.
   always_comb begin
      push_shift = 1'b0;
      replace    = 1'b0;
      pop_shift  = 1'b0;
      if (!clear) begin
         push_shift = push && (pop ? empty : !full);
         replace    = push && pop && !empty;
         pop_shift  = pop && !push && !empty;
      end
   end

   // Per-cell load controls and neighbour data.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ld_up[i] = pop_shift;
         ld_dn[i] = push_shift;
         d_dn[i]  = (i == 0) ? in_data : cell_q[(i == 0) ? 0 : i - 1];
         d_up[i]  = (i == DEPTH - 1) ? '0 : cell_q[(i == DEPTH - 1) ? i : i + 1];
      end
      ld_dn[0] = push_shift || replace || (clear && push);
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      movegen_lifo_cell #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .rst   (rst),
         .clear (clear),
         .ld_up (ld_up[g]),
         .ld_dn (ld_dn[g]),
         .d_up  (d_up[g]),
         .d_dn  (d_dn[g]),
         .q     (cell_q[g])
      );
   end

   // Occupancy counter; saturation follows from the operation decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= push ? CW'(1) : '0;
      end else if (push_shift) begin
         count <= count + CW'(1);
      end else if (pop_shift) begin
         count <= count - CW'(1);
      end
   end

   // Sticky error flags, only dropped by reset or clear.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && !pop && full) overflow <= 1'b1;
         if (pop && !push && empty) underflow <= 1'b1;
      end
   end

   assign top_data  = cell_q[0];
   assign top_valid = !empty;

endmodule

// File: tb/tb_movegen_piece_lifo.sv
// Bench for movegen_piece_lifo: directed scenarios with literal expectations,
// then random push/pop/clear/reset traffic checked every cycle against a
// queue model of the stack.
module tb_movegen_piece_lifo;
   import movegen_pkg::*;

   localparam int WIDTH = 10;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, clear, push, pop;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] top_data;
   logic             top_valid, full, empty, overflow, underflow;
   logic [CW-1:0]    count;

   movegen_piece_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .pop       (pop),
      .in_data   (in_data),
      .top_data  (top_data),
      .top_valid (top_valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // ---------------- scoreboard state ----------------
   logic [WIDTH-1:0] exp_q[$];   // model stack, index 0 = top
   logic             m_ovf, m_unf;
   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc   = 0;

   // Apply one cycle of inputs to the stack model.
   task automatic model_update(input logic r, c, p, o, input logic [WIDTH-1:0] d);
      if (r) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (c) begin
         exp_q.delete();
         if (p) exp_q.push_front(d);
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (p && o) begin
         if (exp_q.size() == 0) exp_q.push_front(d);
         else exp_q[0] = d;
      end else if (p) begin
         if (exp_q.size() == DEPTH) m_ovf = 1'b1;
         else exp_q.push_front(d);
      end else if (o) begin
         if (exp_q.size() == 0) m_unf = 1'b1;
         else void'(exp_q.pop_front());
      end
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic check_model();
      int sz;
      sz = exp_q.size();
      cmp("top_data",  int'(top_data),  (sz > 0) ? int'(exp_q[0]) : 0);
      cmp("count",     int'(count),     sz);
      cmp("full",      int'(full),      (sz == DEPTH) ? 1 : 0);
      cmp("empty",     int'(empty),     (sz == 0) ? 1 : 0);
      cmp("top_valid", int'(top_valid), (sz > 0) ? 1 : 0);
      cmp("overflow",  int'(overflow),  int'(m_ovf));
      cmp("underflow", int'(underflow), int'(m_unf));
   endtask

   // ---------------- driver ----------------
   // Drive one cycle, advance the model, then check just after the edge.
   task automatic step(input logic r, c, p, o, input logic [WIDTH-1:0] d);
      rst = r; clear = c; push = p; pop = o; in_data = d;
      @(posedge clk);
      model_update(r, c, p, o, d);
      #1;
      cyc++;
      check_model();
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d); step(0, 0, 1, 0, d); endtask
   task automatic do_pop();                           step(0, 0, 0, 1, '0); endtask
   task automatic do_clear();                         step(0, 1, 0, 0, '0); endtask

   initial begin
      rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; in_data = '0;
      m_ovf = 1'b0; m_unf = 1'b0;

      // Reset state
      step(1, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);
      cmp("rst_top",   int'(top_data), 0);
      cmp("rst_count", int'(count), 0);
      cmp("rst_empty", int'(empty), 1);
      cmp("rst_full",  int'(full), 0);
      cmp("rst_valid", int'(top_valid), 0);

      // Three pushes then drain
      do_push(10'h1A3); do_push(10'h0C5); do_push(10'h2FF);
      cmp("p3_top", int'(top_data), 'h2FF);
      cmp("p3_count", int'(count), 3);
      do_pop(); cmp("pop1_top", int'(top_data), 'h0C5);
      do_pop(); cmp("pop2_top", int'(top_data), 'h1A3);
      do_pop(); cmp("pop3_empty", int'(empty), 1);
      cmp("pop3_top", int'(top_data), 0);

      // Fill, overflow, pop keeps overflow
      for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(10'h100 + i));
      do_push(10'h155);
      cmp("ovf_full", int'(full), 1);
      cmp("ovf_count", int'(count), 16);
      cmp("ovf_flag", int'(overflow), 1);
      cmp("ovf_top", int'(top_data), 'h10F);
      do_pop();
      cmp("ovf_pop_count", int'(count), 15);
      cmp("ovf_sticky", int'(overflow), 1);
      cmp("ovf_pop_top", int'(top_data), 'h10E);

      // Underflow and clear
      do_clear();
      do_pop();
      cmp("unf_flag", int'(underflow), 1);
      cmp("unf_count", int'(count), 0);
      do_clear();
      cmp("unf_cleared", int'(underflow), 0);

      // Replace at depth 3, and push+pop on empty
      do_push(10'h011); do_push(10'h022); do_push(10'h033);
      step(0, 0, 1, 1, 10'h077);
      cmp("rep_count", int'(count), 3);
      cmp("rep_top", int'(top_data), 'h077);
      do_pop();
      cmp("rep_below", int'(top_data), 'h022);
      do_clear();
      step(0, 0, 1, 1, 10'h077);
      cmp("rep_empty_count", int'(count), 1);
      cmp("rep_empty_top", int'(top_data), 'h077);
      cmp("rep_empty_unf", int'(underflow), 0);

      // Clear+push at depth 5 (pop high too, which clear overrides)
      do_clear();
      for (int i = 0; i < 5; i++) do_push(make_entry(piece_t'(i + 1), square_t'(i * 7)));
      step(0, 1, 1, 1, 10'h3C0);
      cmp("clrp_count", int'(count), 1);
      cmp("clrp_top", int'(top_data), 'h3C0);
      do_pop();
      cmp("clrp_empty", int'(empty), 1);
      cmp("clrp_zero_top", int'(top_data), 0);
      // stale cells must have been zeroed: a push exposes nothing below
      do_push(10'h001); do_pop();
      cmp("clrp_cells0", int'(top_data), 0);

      // Reset mid-sequence with push+pop high
      do_push(10'h2AA); do_push(10'h155); step(0, 0, 1, 0, 10'h0F0);
      step(1, 0, 1, 1, 10'h3FF);
      cmp("mrst_count", int'(count), 0);
      cmp("mrst_top", int'(top_data), 0);
      cmp("mrst_empty", int'(empty), 1);

      // Random traffic against the model
      for (int n = 0; n < 10000; n++) begin
         int r;
         logic rr, cc, pp, oo;
         r  = int'($urandom_range(0, 999));
         rr = (r < 3);
         cc = (r >= 3 && r < 20);
         pp = ($urandom_range(0, 99) < 55);
         oo = ($urandom_range(0, 99) < 45);
         step(rr, cc, pp, oo, WIDTH'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
